dm_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the byte-lane data memory (DataMemory). Port 0 serves the CPU load/store unit and port 1 serves the loader/DMA engine. Each granted request runs as a fixed three-cycle transaction (latch, drive, respond), so sub-word reads, which the memory registers on the clock edge, are always sampled with address and size held stable. Illegal accesses are rejected with an error response and never reach the memory.

---
 rtl/dm_arbiter_if.sv | 30 +++
 rtl/dm_arbiter.sv | 120 ++++++++++++
 tb/tb_dm_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_if.sv
// Request/response bundle for both dm_arbiter ports plus the DataMemory side.
// slave = arbiter view; master = requesters and memory view.
interface dm_arbiter_if;
    logic        REQ0, REQ1;
    logic        WE0, WE1;
    logic [2:0]  I0, I1;
    logic [31:0] A0, A1;
    logic [31:0] WD0, WD1;
    logic        GNT0, GNT1;
    logic        RVALID0, RVALID1;
    logic [31:0] RDATA0, RDATA1;
    logic        ERR0, ERR1;
    logic        M_WE;
    logic [2:0]  M_I;
    logic [31:0] M_A;
    logic [31:0] M_WD;
    logic [31:0] M_RD;

    modport slave (
        input  REQ0, REQ1, WE0, WE1, I0, I1, A0, A1, WD0, WD1, M_RD,
        output GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1, ERR0, ERR1,
        output M_WE, M_I, M_A, M_WD
    );

    modport master (
        output REQ0, REQ1, WE0, WE1, I0, I1, A0, A1, WD0, WD1, M_RD,
        input  GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1, ERR0, ERR1,
        input  M_WE, M_I, M_A, M_WD
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter for DataMemory; each grant runs a fixed
// latch/drive/respond sequence and illegal accesses never reach the memory.
module dm_arbiter #(
    parameter int unsigned MEM_BYTES = 256
) (
    input logic          CLK,
    input logic          RSTn,
    dm_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      r_state, w_state_next;
    logic        r_last, r_port, r_we, r_err;
    logic [2:0]  r_i;
    logic [31:0] r_a, r_wd;

    logic        w_req_any, w_pick1, w_grant;
    logic        w_we, w_err;
    logic [2:0]  w_i;
    logic [31:0] w_a, w_wd, w_rdata;

    assign w_req_any = bus.REQ0 | bus.REQ1;
    // Port 1 wins when alone, or on a tie when port 0 was granted last.
    assign w_pick1   = bus.REQ1 & (~bus.REQ0 | ~r_last);
    assign w_grant   = RSTn & (r_state == StIdle) & w_req_any;

    assign w_we = w_pick1 ? bus.WE1 : bus.WE0;
    assign w_i  = w_pick1 ? bus.I1  : bus.I0;
    assign w_a  = w_pick1 ? bus.A1  : bus.A0;
    assign w_wd = w_pick1 ? bus.WD1 : bus.WD0;

    always_comb begin
        w_err = 1'b0;
        case (w_i)
            3'd0:    w_err = 1'b0;
            3'd1:    w_err = w_a[0];
            3'd2:    w_err = |w_a[1:0];
            3'd4:    w_err = w_we;
            3'd5:    w_err = w_we | w_a[0];
            default: w_err = 1'b1;
        endcase
        if (w_a >= MEM_BYTES) begin
            w_err = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (w_req_any) w_state_next = StAccess;
            StAccess: w_state_next = StResp;
            StResp:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= StIdle;
            r_last  <= 1'b1;
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_i     <= 3'd0;
            r_a     <= 32'd0;
            r_wd    <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_last <= w_pick1;
                r_port <= w_pick1;
                r_we   <= w_we;
                r_err  <= w_err;
                r_i    <= w_i;
                r_a    <= w_a;
                r_wd   <= w_wd;
            end
        end
    end

    assign w_rdata = (~r_we & ~r_err) ? bus.M_RD : 32'd0;

    // Outputs are gated by RSTn so a reset cycle never writes or responds.
    always_comb begin
        bus.GNT0    = w_grant & ~w_pick1;
        bus.GNT1    = w_grant & w_pick1;
        bus.RVALID0 = 1'b0;
        bus.RVALID1 = 1'b0;
        bus.RDATA0  = 32'd0;
        bus.RDATA1  = 32'd0;
        bus.ERR0    = 1'b0;
        bus.ERR1    = 1'b0;
        bus.M_WE    = 1'b0;
        bus.M_I     = 3'd2;
        bus.M_A     = 32'd0;
        bus.M_WD    = 32'd0;
        if (RSTn && r_state == StAccess) begin
            bus.M_WE = r_we & ~r_err;
            bus.M_I  = r_i;
            bus.M_A  = r_a;
            bus.M_WD = r_wd;
        end
        if (RSTn && r_state == StResp) begin
            bus.M_I  = r_i;
            bus.M_A  = r_a;
            bus.M_WD = r_wd;
            if (r_port) begin
                bus.RVALID1 = 1'b1;
                bus.RDATA1  = w_rdata;
                bus.ERR1    = r_err;
            end else begin
                bus.RVALID0 = 1'b1;
                bus.RDATA0  = w_rdata;
                bus.ERR0    = r_err;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small byte-lane memory model attached.
module tb_dm_arbiter;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    dm_arbiter_if bus ();

    dm_arbiter #(.MEM_BYTES(256)) dut (
        .CLK  (clk),
        .RSTn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256] = '{default: 8'h00};

    function automatic logic [31:0] mem_rd(input logic [2:0] i, input logic [31:0] a);
        logic [7:0] b0, b1, b2, b3;
        if (a >= 32'd256) return 32'd0;
        b0 = mem[a[7:0]];
        b1 = mem[8'(a[7:0] + 8'd1)];
        b2 = mem[8'(a[7:0] + 8'd2)];
        b3 = mem[8'(a[7:0] + 8'd3)];
        case (i)
            3'd0:    return {{24{b0[7]}}, b0};
            3'd1:    return {{16{b1[7]}}, b1, b0};
            3'd2:    return {b3, b2, b1, b0};
            3'd4:    return {24'd0, b0};
            3'd5:    return {16'd0, b1, b0};
            default: return 32'd0;
        endcase
    endfunction

    // Memory registers reads on the clock edge; unsigned and illegal sizes never write.
    always @(posedge clk) begin
        if (bus.M_WE && bus.M_A < 32'd256) begin
            case (bus.M_I)
                3'd0: mem[bus.M_A[7:0]] <= bus.M_WD[7:0];
                3'd1: begin
                    mem[bus.M_A[7:0]]             <= bus.M_WD[7:0];
                    mem[8'(bus.M_A[7:0] + 8'd1)]  <= bus.M_WD[15:8];
                end
                3'd2: begin
                    mem[bus.M_A[7:0]]             <= bus.M_WD[7:0];
                    mem[8'(bus.M_A[7:0] + 8'd1)]  <= bus.M_WD[15:8];
                    mem[8'(bus.M_A[7:0] + 8'd2)]  <= bus.M_WD[23:16];
                    mem[8'(bus.M_A[7:0] + 8'd3)]  <= bus.M_WD[31:24];
                end
                default: ;
            endcase
        end
        bus.M_RD <= mem_rd(bus.M_I, bus.M_A);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit p, input logic req, input logic we, input logic [2:0] i,
                         input logic [31:0] a, input logic [31:0] wd);
        if (p) begin
            bus.REQ1 = req; bus.WE1 = we; bus.I1 = i; bus.A1 = a; bus.WD1 = wd;
        end else begin
            bus.REQ0 = req; bus.WE0 = we; bus.I0 = i; bus.A0 = a; bus.WD0 = wd;
        end
    endtask

    function automatic logic gnt_of(input bit p);
        return p ? bus.GNT1 : bus.GNT0;
    endfunction

    function automatic logic rv_of(input bit p);
        return p ? bus.RVALID1 : bus.RVALID0;
    endfunction

    function automatic logic err_of(input bit p);
        return p ? bus.ERR1 : bus.ERR0;
    endfunction

    function automatic logic [31:0] rd_of(input bit p);
        return p ? bus.RDATA1 : bus.RDATA0;
    endfunction

    task automatic txn(input string tag, input bit p, input logic we, input logic [2:0] i,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
        bit   got;
        logic exp_mwe;
        exp_mwe = we & ~exp_err;
        @(posedge clk); #1;
        drive(p, 1'b1, we, i, a, wd);
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (gnt_of(p)) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, ".gnt"}, 32'(got), 32'd1);
        check({tag, ".gnt_other"}, 32'(gnt_of(!p)), 32'd0);
        // Scramble fields after the grant: they must be ignored.
        @(posedge clk); #1;
        drive(p, 1'b0, ~we, 3'd7, 32'hFFFF_FFFC, 32'h5555_5555);
        @(negedge clk);
        check({tag, ".m_we"}, 32'(bus.M_WE), 32'(exp_mwe));
        check({tag, ".m_i"}, 32'(bus.M_I), 32'(i));
        check({tag, ".m_a"}, bus.M_A, a);
        if (exp_mwe) check({tag, ".m_wd"}, bus.M_WD, wd);
        @(negedge clk);
        check({tag, ".rvalid"}, 32'(rv_of(p)), 32'd1);
        check({tag, ".rvalid_other"}, 32'(rv_of(!p)), 32'd0);
        check({tag, ".err"}, 32'(err_of(p)), 32'(exp_err));
        check({tag, ".rdata"}, rd_of(p), exp_rd);
        check({tag, ".m_we_resp"}, 32'(bus.M_WE), 32'd0);
        @(negedge clk);
        check({tag, ".rvalid_end"}, 32'(rv_of(p)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        drive(1'b1, 1'b0, 1'b0, 3'd2, 32'd0, 32'd0);
        drive(1'b0, 1'b1, 1'b1, 3'd2, 32'd8, 32'hDEAD_BEEF);

        // Reset held two cycles with REQ0 pending.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst.gnt0", 32'(bus.GNT0), 32'd0);
            check("rst.m_we", 32'(bus.M_WE), 32'd0);
            check("rst.m_i", 32'(bus.M_I), 32'd2);
            check("rst.rvalid0", 32'(bus.RVALID0), 32'd0);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rel.gnt0", 32'(bus.GNT0), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("rel.m_we", 32'(bus.M_WE), 32'd1);
        check("rel.m_a", bus.M_A, 32'd8);
        check("rel.m_wd", bus.M_WD, 32'hDEAD_BEEF);
        @(negedge clk);
        check("rel.rvalid0", 32'(bus.RVALID0), 32'd1);
        check("rel.err0", 32'(bus.ERR0), 32'd0);
        check("rel.m_we_resp", 32'(bus.M_WE), 32'd0);
        @(negedge clk);
        check("rel.rvalid_end", 32'(bus.RVALID0), 32'd0);

        txn("ld_word", 1'b0, 1'b0, 3'd2, 32'd8, 32'd0, 32'hDEAD_BEEF, 1'b0);
        txn("st_word", 1'b0, 1'b1, 3'd2, 32'd8, 32'h0000_80FF, 32'd0, 1'b0);
        txn("ld_sb", 1'b0, 1'b0, 3'd0, 32'd8, 32'd0, 32'hFFFF_FFFF, 1'b0);
        txn("ld_ub", 1'b0, 1'b0, 3'd4, 32'd9, 32'd0, 32'h0000_0080, 1'b0);
        txn("ld_sh", 1'b0, 1'b0, 3'd1, 32'd8, 32'd0, 32'hFFFF_80FF, 1'b0);
        txn("p1_st_h", 1'b1, 1'b1, 3'd1, 32'd10, 32'h0000_1234, 32'd0, 1'b0);
        txn("p1_ld_w", 1'b1, 1'b0, 3'd2, 32'd8, 32'd0, 32'h1234_80FF, 1'b0);
        txn("p1_ld_uh", 1'b1, 1'b0, 3'd5, 32'd10, 32'd0, 32'h0000_1234, 1'b0);

        txn("e_st_i5", 1'b0, 1'b1, 3'd5, 32'd8, 32'hFFFF_FFFF, 32'd0, 1'b1);
        txn("e_w_a2", 1'b0, 1'b0, 3'd2, 32'd2, 32'd0, 32'd0, 1'b1);
        txn("e_h_a3", 1'b0, 1'b0, 3'd1, 32'd3, 32'd0, 32'd0, 1'b1);
        txn("e_a256", 1'b1, 1'b0, 3'd0, 32'd256, 32'd0, 32'd0, 1'b1);
        txn("e_st256", 1'b0, 1'b1, 3'd2, 32'd256, 32'h0BAD_F00D, 32'd0, 1'b1);
        txn("e_i3", 1'b0, 1'b0, 3'd3, 32'd8, 32'd0, 32'd0, 1'b1);
        txn("untouched", 1'b0, 1'b0, 3'd2, 32'd8, 32'd0, 32'h1234_80FF, 1'b0);
        txn("p1_ld12", 1'b1, 1'b0, 3'd2, 32'd12, 32'd0, 32'd0, 1'b0);

        // Both ports requesting continuously; port 1 was granted last.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 3'd2, 32'd8, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 3'd2, 32'd8, 32'd0);
        for (int k = 0; k < 12; k++) begin
            logic [1:0] exp_g, exp_v;
            exp_g = (k == 0 || k == 6) ? 2'b01 : (k == 3 || k == 9) ? 2'b10 : 2'b00;
            exp_v = (k == 2 || k == 8) ? 2'b01 : (k == 5 || k == 11) ? 2'b10 : 2'b00;
            @(negedge clk);
            check($sformatf("cont.gnt%0d", k), 32'({bus.GNT1, bus.GNT0}), 32'(exp_g));
            check($sformatf("cont.rv%0d", k), 32'({bus.RVALID1, bus.RVALID0}), 32'(exp_v));
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 3'd2, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd2, 32'd0, 32'd0);

        // Reset arriving during the ACCESS cycle of a store.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 3'd2, 32'd16, 32'hA5A5_A5A5);
        @(negedge clk);
        check("rstacc.gnt0", 32'(bus.GNT0), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 3'd2, 32'd0, 32'd0);
        rstn = 1'b0;
        @(negedge clk);
        check("rstacc.m_we", 32'(bus.M_WE), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rstacc.rvalid0", 32'(bus.RVALID0), 32'd0);
            check("rstacc.m_we_after", 32'(bus.M_WE), 32'd0);
        end
        txn("after_rst", 1'b0, 1'b0, 3'd2, 32'd16, 32'd0, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
